// File: rtl/conv_enc_punc_pkg.sv
// -----------------------------------------------------------------------------
// conv_enc_punc_pkg
// Shared constants and helpers for the K=7 convolutional encoder/puncturer.
//   K, MEM_DEPTH  : constraint length and encoder memory depth.
//   GEN_A, GEN_B  : generator polynomials 133/171 octal. MSB taps the current
//                   bit, lower bits tap successively older history bits.
//   RATE_*        : rate codes as carried on di_rate.
//   TAIL_LEN      : number of zero tail bits flushed after each frame.
//   coded_beat_t  : one coded output beat (bits, both-valid flag, last flag).
// -----------------------------------------------------------------------------
package conv_enc_punc_pkg;

  localparam int K         = 7;
  localparam int MEM_DEPTH = K - 1;
  localparam int TAIL_LEN  = MEM_DEPTH;

  localparam logic [K-1:0] GEN_A = 7'o133;
  localparam logic [K-1:0] GEN_B = 7'o171;

  localparam logic [1:0] RATE_1_2  = 2'b00;
  localparam logic [1:0] RATE_2_3  = 2'b01;
  localparam logic [1:0] RATE_3_4  = 2'b10;
  localparam logic [1:0] RATE_RSVD = 2'b11;

  // Value of the tail counter on the final tail step.
  localparam logic [2:0] TAIL_LAST = 3'(TAIL_LEN - 1);

  typedef struct packed {
    logic [1:0] bits;
    logic       two;
    logic       last;
  } coded_beat_t;

  // Reserved code falls back to rate 1/2 so the puncturer only sees 3 cases.
  function automatic logic [1:0] rate_norm(input logic [1:0] rate);
    return (rate == RATE_RSVD) ? RATE_1_2 : rate;
  endfunction

  // Parity of the generator taps over {b, s[0], s[1], ..., s[MEM_DEPTH-1]},
  // where s[0] is the most recent previous bit.
  function automatic logic gen_parity(input logic [K-1:0]         gen,
                                      input logic                 b,
                                      input logic [MEM_DEPTH-1:0] s);
    logic acc;
    acc = gen[K-1] & b;
    for (int i = 0; i < MEM_DEPTH; i++) begin
      acc = acc ^ (gen[K-2-i] & s[i]);
    end
    return acc;
  endfunction

endpackage

// File: rtl/conv_enc_punc_punc_map.sv
// -----------------------------------------------------------------------------
// conv_enc_punc_punc_map
// Combinational puncture table. Given the latched rate, the current puncture
// phase and the mother-code pair (A,B), selects which coded bits are sent.
//   rate_i     : normalized rate code (reserved already mapped to 1/2).
//   p_i        : puncture phase of the bit being encoded.
//   a_i, b_i   : rate-1/2 coded bits for that input bit.
//   bits_o     : bits_o[0] first in transmit order; a lone bit sits there.
//   two_o      : 1 when both bits_o are valid.
//   p_next_o   : phase for the following encoded bit.
// -----------------------------------------------------------------------------
module conv_enc_punc_punc_map
  import conv_enc_punc_pkg::*;
(
  input  logic [1:0] rate_i,
  input  logic [1:0] p_i,
  input  logic       a_i,
  input  logic       b_i,
  output logic [1:0] bits_o,
  output logic       two_o,
  output logic [1:0] p_next_o
);

  always_comb begin
    bits_o   = {b_i, a_i};
    two_o    = 1'b1;
    p_next_o = 2'd0;
    case (rate_i)
      RATE_2_3: begin
        // Pattern A:11 B:10
        if (p_i == 2'd0) begin
          p_next_o = 2'd1;
        end else begin
          bits_o   = {1'b0, a_i};
          two_o    = 1'b0;
          p_next_o = 2'd0;
        end
      end
      RATE_3_4: begin
        // Pattern A:110 B:101
        case (p_i)
          2'd0: begin
            p_next_o = 2'd1;
          end
          2'd1: begin
            bits_o   = {1'b0, a_i};
            two_o    = 1'b0;
            p_next_o = 2'd2;
          end
          default: begin
            bits_o   = {1'b0, b_i};
            two_o    = 1'b0;
            p_next_o = 2'd0;
          end
        endcase
      end
      default: begin
        bits_o   = {b_i, a_i};
        two_o    = 1'b1;
        p_next_o = 2'd0;
      end
    endcase
  end

endmodule

// File: rtl/conv_enc_punc.sv
// -----------------------------------------------------------------------------
// conv_enc_punc
// K=7 rate-1/2 convolutional encoder (133/171 octal) with puncturing to 2/3 or
// 3/4 and an automatic 6-bit zero tail appended after every frame.
//   clk, rst_n            : clock, asynchronous active-low reset.
//   di_valid/do_ready     : input handshake, one data bit per accepted beat.
//   di_bit, di_sof,di_eof : data bit and frame delimiters.
//   di_rate               : rate code, sampled only on the SOF beat.
//   do_valid/di_ready     : output handshake.
//   do_bits, do_two       : coded bits (do_bits[0] first) and both-valid flag.
//   do_last               : final tail beat of the frame.
// -----------------------------------------------------------------------------
module conv_enc_punc
  import conv_enc_punc_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       di_valid,
  output logic       do_ready,
  input  logic       di_bit,
  input  logic       di_sof,
  input  logic       di_eof,
  input  logic [1:0] di_rate,
  output logic       do_valid,
  input  logic       di_ready,
  output logic [1:0] do_bits,
  output logic       do_two,
  output logic       do_last
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ENC  = 2'd1;
  localparam logic [1:0] ST_TAIL = 2'd2;

  logic [1:0]           state_q, state_d;
  logic [MEM_DEPTH-1:0] sr_q, sr_d;
  logic [1:0]           p_q, p_d;
  logic [1:0]           rate_q, rate_d;
  logic [2:0]           tail_cnt_q, tail_cnt_d;
  logic                 valid_q, valid_d;
  coded_beat_t          beat_q, beat_d;

  // Operands of the bit being encoded this cycle (if any).
  logic                 enc_fire;
  logic                 enc_last;
  logic                 enc_bit;
  logic [MEM_DEPTH-1:0] enc_sr;
  logic [1:0]           enc_p;
  logic [1:0]           enc_rate;
  logic                 enc_a;
  logic                 enc_b;

  logic [1:0]           pm_bits;
  logic                 pm_two;
  logic [1:0]           pm_p_next;

  logic                 out_free;
  logic                 accept;

  // Output register can take a new beat when empty or being drained now.
  assign out_free = !valid_q || di_ready;
  assign do_ready = (state_q != ST_TAIL) && out_free;
  assign accept   = di_valid && do_ready;

  // Control: decide whether a bit is encoded this cycle and with which state.
  always_comb begin
    state_d    = state_q;
    tail_cnt_d = tail_cnt_q;
    rate_d     = rate_q;
    enc_fire   = 1'b0;
    enc_last   = 1'b0;
    enc_bit    = di_bit;
    enc_sr     = sr_q;
    enc_p      = p_q;
    enc_rate   = rate_q;
    case (state_q)
      ST_IDLE: begin
        // SOF starts from a cleared register and phase, with the fresh rate.
        enc_sr   = '0;
        enc_p    = 2'd0;
        enc_rate = rate_norm(di_rate);
        if (accept && di_sof) begin
          enc_fire   = 1'b1;
          rate_d     = rate_norm(di_rate);
          tail_cnt_d = 3'd0;
          state_d    = di_eof ? ST_TAIL : ST_ENC;
        end
      end
      ST_ENC: begin
        if (accept) begin
          enc_fire = 1'b1;
          if (di_eof) begin
            tail_cnt_d = 3'd0;
            state_d    = ST_TAIL;
          end
        end
      end
      ST_TAIL: begin
        enc_bit = 1'b0;
        if (out_free) begin
          enc_fire   = 1'b1;
          tail_cnt_d = tail_cnt_q + 3'd1;
          if (tail_cnt_q == TAIL_LAST) begin
            enc_last = 1'b1;
            state_d  = ST_IDLE;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign enc_a = gen_parity(GEN_A, enc_bit, enc_sr);
  assign enc_b = gen_parity(GEN_B, enc_bit, enc_sr);

  conv_enc_punc_punc_map u_punc_map (
    .rate_i   (enc_rate),
    .p_i      (enc_p),
    .a_i      (enc_a),
    .b_i      (enc_b),
    .bits_o   (pm_bits),
    .two_o    (pm_two),
    .p_next_o (pm_p_next)
  );

  // Datapath: shift register, phase and output register updates.
  always_comb begin
    sr_d    = sr_q;
    p_d     = p_q;
    valid_d = valid_q;
    beat_d  = beat_q;
    if (enc_fire) begin
      sr_d        = {enc_sr[MEM_DEPTH-2:0], enc_bit};
      p_d         = pm_p_next;
      valid_d     = 1'b1;
      beat_d.bits = pm_bits;
      beat_d.two  = pm_two;
      beat_d.last = enc_last;
    end else if (di_ready) begin
      valid_d     = 1'b0;
      beat_d.last = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      sr_q       <= '0;
      p_q        <= 2'd0;
      rate_q     <= RATE_1_2;
      tail_cnt_q <= 3'd0;
      valid_q    <= 1'b0;
      beat_q     <= '0;
    end else begin
      state_q    <= state_d;
      sr_q       <= sr_d;
      p_q        <= p_d;
      rate_q     <= rate_d;
      tail_cnt_q <= tail_cnt_d;
      valid_q    <= valid_d;
      beat_q     <= beat_d;
    end
  end

  assign do_valid = valid_q;
  assign do_bits  = beat_q.bits;
  assign do_two   = beat_q.two;
  assign do_last  = beat_q.last;

endmodule

// File: tb/tb_conv_enc_punc.sv
// -----------------------------------------------------------------------------
// tb_conv_enc_punc
// Directed bench for conv_enc_punc: hand-computed short frames, a golden
// generator-polynomial model for longer random frames, backpressure, protocol
// edges and reset mid-frame.
// -----------------------------------------------------------------------------
module tb_conv_enc_punc;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       di_valid = 1'b0;
  logic       di_bit = 1'b0;
  logic       di_sof = 1'b0;
  logic       di_eof = 1'b0;
  logic [1:0] di_rate = 2'b00;
  logic       di_ready = 1'b1;
  logic       do_ready;
  logic       do_valid;
  logic [1:0] do_bits;
  logic       do_two;
  logic       do_last;

  int n_assert = 0;
  int n_fail   = 0;
  int ready_mode = 0;  // 0: always ready, 1: random 50%, 2: held low

  bit         din[0:127];
  bit         exp_q[$];
  bit         stream[$];
  logic [3:0] beats[$];  // {last, two, bits[1], bits[0]}
  int         lasts = 0;

  conv_enc_punc dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .di_valid (di_valid),
    .do_ready (do_ready),
    .di_bit   (di_bit),
    .di_sof   (di_sof),
    .di_eof   (di_eof),
    .di_rate  (di_rate),
    .do_valid (do_valid),
    .di_ready (di_ready),
    .do_bits  (do_bits),
    .do_two   (do_two),
    .do_last  (do_last)
  );

  always #5 clk = ~clk;

  // Downstream ready driver.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        1:       di_ready = ($urandom_range(0, 1) != 0);
        2:       di_ready = 1'b0;
        default: di_ready = 1'b1;
      endcase
    end
  end

  // Output monitor: records every consumed beat, one line each.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && do_valid && di_ready) begin
        beats.push_back({do_last, do_two, do_bits});
        stream.push_back(do_bits[0]);
        if (do_two) stream.push_back(do_bits[1]);
        if (do_last) lasts++;
        $display("beat %0d: bits=%b two=%b last=%b", beats.size(), do_bits, do_two, do_last);
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic clear_cap();
    beats.delete();
    stream.delete();
    lasts = 0;
  endtask

  // Drives n bits from din[]; caller is positioned just after a rising edge.
  task automatic send_frame(input int n, input logic [1:0] r, input bit with_eof,
                            input int sof_again);
    for (int i = 0; i < n; i++) begin
      int guard;
      bit took;
      di_valid = 1'b1;
      di_bit   = din[i];
      di_sof   = (i == 0) || (i == sof_again);
      di_eof   = with_eof && (i == n - 1);
      di_rate  = (i == 0) ? r : ~r;  // mid-frame rate noise must be ignored
      guard = 0;
      took  = 1'b0;
      while (!took && guard < 1000) begin
        @(negedge clk);
        took = do_ready;
        @(posedge clk);
        #1;
        guard++;
      end
      if (!took) begin
        n_assert++;
        n_fail++;
        $error("FAIL send_timeout: observed no accept, expected accept within 1000 cycles");
      end
    end
    di_valid = 1'b0;
    di_sof   = 1'b0;
    di_eof   = 1'b0;
  endtask

  task automatic wait_done(input int target);
    int guard;
    guard = 0;
    while (lasts < target && guard < 3000) begin
      @(negedge clk);
      guard++;
    end
    if (lasts < target) begin
      n_assert++;
      n_fail++;
      $error("FAIL frame_timeout: observed %0d last beats, expected %0d", lasts, target);
    end
    @(posedge clk);
    #1;
  endtask

  // Golden model: sliding window against the octal generators, then a
  // keep-mask per puncture phase.
  task automatic build_expected(input int n, input logic [1:0] r);
    bit         h[6];
    logic [6:0] w;
    logic [6:0] ga;
    logic [6:0] gb;
    bit         a;
    bit         bb;
    bit         b;
    int         ph;
    ga = 7'o133;
    gb = 7'o171;
    for (int k = 0; k < 6; k++) h[k] = 1'b0;
    exp_q.delete();
    for (int i = 0; i < n + 6; i++) begin
      b  = (i < n) ? din[i] : 1'b0;
      w  = {b, h[0], h[1], h[2], h[3], h[4], h[5]};
      a  = ^(w & ga);
      bb = ^(w & gb);
      for (int k = 5; k > 0; k--) h[k] = h[k-1];
      h[0] = b;
      case (r)
        2'b01: begin
          ph = i % 2;
          exp_q.push_back(a);
          if (ph == 0) exp_q.push_back(bb);
        end
        2'b10: begin
          ph = i % 3;
          if (ph != 2) exp_q.push_back(a);
          if (ph != 1) exp_q.push_back(bb);
        end
        default: begin
          exp_q.push_back(a);
          exp_q.push_back(bb);
        end
      endcase
    end
  endtask

  task automatic check_stream(input string tag, input int n);
    int mism;
    int lc;
    int lim;
    mism = 0;
    lc   = 0;
    chk({tag, "_beats"}, beats.size(), n + 6);
    chk({tag, "_len"}, stream.size(), exp_q.size());
    lim = (stream.size() < exp_q.size()) ? stream.size() : exp_q.size();
    for (int i = 0; i < lim; i++) if (stream[i] !== exp_q[i]) mism++;
    chk({tag, "_bit_errors"}, mism, 0);
    foreach (beats[i]) if (beats[i][3]) lc++;
    chk({tag, "_last_count"}, lc, 1);
    if (beats.size() > 0) chk({tag, "_last_pos"}, beats[beats.size()-1][3], 1);
  endtask

  initial begin
    logic [3:0] tbl1[7];
    logic [3:0] tbl2[7];
    bit         s34[10];
    tbl1 = '{4'b0111, 4'b0110, 4'b0111, 4'b0111, 4'b0100, 4'b0101, 4'b1111};
    tbl2 = '{4'b0111, 4'b0000, 4'b0001, 4'b0111, 4'b0000, 4'b0000, 4'b1111};
    s34  = '{1, 1, 0, 1, 1, 1, 0, 0, 1, 1};

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_do_valid", do_valid, 0);
    chk("rst_do_ready", do_ready, 1);
    chk("rst_do_bits", do_bits, 0);
    chk("rst_do_two", do_two, 0);
    chk("rst_do_last", do_last, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Rate 1/2, single bit 1
    clear_cap();
    din[0] = 1'b1;
    send_frame(1, 2'b00, 1'b1, -1);
    wait_done(1);
    chk("r12_beats", beats.size(), 7);
    for (int i = 0; i < 7 && i < beats.size(); i++) chk($sformatf("r12_beat%0d", i), beats[i], tbl1[i]);

    // Rate 3/4, single bit 1
    clear_cap();
    send_frame(1, 2'b10, 1'b1, -1);
    wait_done(1);
    chk("r34_beats", beats.size(), 7);
    for (int i = 0; i < 7 && i < beats.size(); i++) chk($sformatf("r34_beat%0d", i), beats[i], tbl2[i]);
    chk("r34_len", stream.size(), 10);
    for (int i = 0; i < 10 && i < stream.size(); i++) chk($sformatf("r34_bit%0d", i), stream[i], s34[i]);

    // Rate 2/3, 12 zero bits
    clear_cap();
    for (int i = 0; i < 12; i++) din[i] = 1'b0;
    send_frame(12, 2'b01, 1'b1, -1);
    wait_done(1);
    chk("r23_beats", beats.size(), 18);
    for (int i = 0; i < 18 && i < beats.size(); i++)
      chk($sformatf("r23_beat%0d", i), beats[i], {(i == 17), (i % 2 == 0), 2'b00});

    // Random backpressure, 100-bit random frames at every rate code
    ready_mode = 1;
    for (int r = 0; r < 4; r++) begin
      clear_cap();
      for (int i = 0; i < 100; i++) din[i] = ($urandom_range(0, 1) != 0);
      send_frame(100, 2'(r), 1'b1, -1);
      wait_done(1);
      build_expected(100, 2'(r));
      check_stream($sformatf("bp_rate%0d", r), 100);
    end
    ready_mode = 0;
    @(posedge clk);
    #1;

    // Non-SOF beats in IDLE are dropped
    clear_cap();
    di_valid = 1'b1;
    di_sof   = 1'b0;
    di_bit   = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    di_valid = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    chk("idle_drop_beats", beats.size(), 0);
    chk("idle_drop_valid", do_valid, 0);

    // Mid-frame SOF encoded as data
    clear_cap();
    for (int i = 0; i < 10; i++) din[i] = ($urandom_range(0, 1) != 0);
    din[4] = 1'b1;
    send_frame(10, 2'b10, 1'b1, 4);
    wait_done(1);
    build_expected(10, 2'b10);
    check_stream("mid_sof", 10);

    // do_ready low through the tail, then back-to-back SOF
    clear_cap();
    for (int i = 0; i < 5; i++) din[i] = ($urandom_range(0, 1) != 0);
    send_frame(5, 2'b01, 1'b1, -1);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk($sformatf("tail_ready%0d", i), do_ready, 0);
    end
    @(negedge clk);
    chk("tail_end_last", do_last, 1);
    chk("tail_end_ready", do_ready, 1);
    di_valid = 1'b1;
    di_sof   = 1'b1;
    di_eof   = 1'b1;
    di_bit   = 1'b1;
    di_rate  = 2'b00;
    @(posedge clk);
    #1;
    di_valid = 1'b0;
    di_sof   = 1'b0;
    di_eof   = 1'b0;
    wait_done(2);
    chk("b2b_beats", beats.size(), 18);
    if (beats.size() >= 18) begin
      chk("b2b_prev_last", beats[10][3], 1);
      for (int k = 0; k < 7; k++) chk($sformatf("b2b_beat%0d", k), beats[11+k], tbl1[k]);
    end

    // Reset mid-frame at rate 3/4, then a fresh rate 1/2 frame
    clear_cap();
    for (int i = 0; i < 40; i++) din[i] = ($urandom_range(0, 1) != 0);
    send_frame(40, 2'b10, 1'b0, -1);
    rst_n = 1'b0;
    #2;
    chk("midrst_valid", do_valid, 0);
    chk("midrst_ready", do_ready, 1);
    chk("midrst_last", do_last, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    clear_cap();
    for (int i = 0; i < 20; i++) din[i] = ($urandom_range(0, 1) != 0);
    send_frame(20, 2'b00, 1'b1, -1);
    wait_done(1);
    build_expected(20, 2'b00);
    check_stream("post_rst", 20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/conv_enc_punc.md
# conv_enc_punc

Transmit-side channel encoder for the OFDM baseband: a K=7, rate-1/2 convolutional encoder (generators 133/171 octal) with 802.11a-style puncturing to rate 2/3 or 3/4 and automatic 6-bit zero-tail insertion per frame. It sits between the scrambler and the interleaver and produces the coded stream that the receive-side Viterbi decoder (ACS/traceback chain) consumes. Input and output use valid/ready handshakes; one input bit is consumed per accepted beat.

## Interface
Parameters:
- none; K, generators and rate codes come from global_define.vh.

Ports:
- clk  in  1  single clock, all logic rising-edge.
- rst_n  in  1  asynchronous, active-low reset.
- di_valid  in  1  input bit valid.
- do_ready  out  1  encoder can accept an input beat.
- di_bit  in  1  uncoded data bit.
- di_sof  in  1  first bit of frame; qualified by di_valid & do_ready.
- di_eof  in  1  last data bit of frame; may coincide with di_sof.
- di_rate  in  2  00 = 1/2, 01 = 2/3, 10 = 3/4, 11 = reserved (treated as 1/2); sampled on the SOF beat only.
- do_valid  out  1  coded output valid.
- di_ready  in  1  downstream accepts coded output.
- do_bits  out  2  coded bits; do_bits[0] is always the first bit in transmit order.
- do_two  out  1  1 = both do_bits valid (order A then B), 0 = only do_bits[0] valid.
- do_last  out  1  marks the final coded beat of the frame (last tail bit).

## Operation
- FSM states: IDLE, ENC, TAIL.
- IDLE: do_ready=1; beats without di_sof are dropped. An SOF beat clears the 6-bit shift register s and the puncture phase p, latches the rate, encodes the bit, and goes to ENC (or TAIL if di_eof is also set).
- ENC: do_ready=1 when the output register is free or draining. Each accepted beat encodes di_bit. di_sof in ENC is ignored, and the bit is encoded as data. A beat with di_eof moves to TAIL with tail count 0.
- TAIL: do_ready=0. Six zero bits are encoded internally, one per cycle the output register is free. After the 6th, do_last is set on that beat and the FSM returns to IDLE.
- Encoding, where b is the current bit and s[0] is the most recent previous bit:
  - A = b^s[1]^s[2]^s[4]^s[5]
  - B = b^s[0]^s[1]^s[2]^s[5]
  - Then s <= {s[4:0], b}.
- Puncturing, with p counting encoded bits (data and tail) modulo the pattern length:
  - Rate 1/2: always emit A,B (do_two=1).
  - Rate 2/3: p=0 emits A,B; p=1 emits A only.
  - Rate 3/4: p=0 emits A,B; p=1 emits A only; p=2 emits B only.
  - A lone bit is always placed on do_bits[0].
- Every encoded bit yields a non-empty output beat; no beat has zero bits.

## Timing
- Reset values: FSM=IDLE; s=0; p=0; do_valid=0; do_bits=0; do_two=0; do_last=0; do_ready=1.
- Latency: 1 cycle from an accepted input beat (or internal tail step) to do_valid.
- The output register holds its value while do_valid & !di_ready.
- do_ready = !TAIL & (!do_valid | di_ready). This gives full throughput of 1 bit/cycle with no bubbles under continuous ready.
- A frame of N data bits produces exactly N+6 output beats. The last data bit and the first tail step are in consecutive cycles when di_ready=1.
- rst_n asserted mid-frame: immediate return to reset values. The partial frame is discarded and the next frame requires SOF.
- Rate changes take effect only at SOF; mid-frame changes on di_rate are ignored.

## Structure
- global_define.vh holds the constraint length (7), the memory depth (6), generator constants 133/171 octal, rate codes, and the tail length (6).
- One natural sub-module is punc_map. It is combinational: inputs are the latched rate, p, A and B; outputs are do_bits, do_two and next p. This keeps the pattern table isolated and reusable by a future depuncturer.
- The top level holds the FSM, the shift register, the tail counter and the output register.

## Test plan
- Rate 1/2, single bit 1 (SOF=EOF): 7 beats (A,B) = 11,01,11,11,00,10,11, with do_last on the 7th.
- Rate 3/4, single bit 1: coded stream 1,1,0,1,1,1,0,0,1,1. do_two pattern is 1,0,0,1,0,0,1.
- Rate 2/3, 12 zero data bits: 18 beats, all-zero bits, with do_two alternating 1,0 starting at 1.
- Backpressure: random di_ready (50%) on a 100-bit random frame at every rate. The coded stream must match a golden model bit-exactly, and no beat may be lost or duplicated.
- Protocol edges:
  - Non-SOF beats in IDLE are dropped.
  - A mid-frame SOF is treated as data.
  - do_ready stays low for all 6 tail cycles.
  - A back-to-back next-frame SOF is accepted the cycle after do_last is consumed.
- Reset mid-frame (after 40 bits at rate 3/4), then a new frame at rate 1/2: the output matches a fresh encode with s=0, p=0.
